// File: rtl/prefix_subtractor_pipe.sv
// Three-stage Kogge-Stone prefix subtractor: diff = a - b - b_in, computed as a + ~b + ~b_in.
// Define PSUB_FLAGS_EN to add the registered zero / lt_u / lt_s result flags.
module prefix_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
`ifdef PSUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             lt_u,
    output logic             lt_s
`endif
);

    localparam int LVLS   = $clog2(WIDTH);
    localparam int LVL_S2 = (LVLS + 1) / 2;

    // Applies Kogge-Stone levels lo..hi-1; returns group propagate when want_p, else group generate.
    function automatic logic [WIDTH-1:0] ks_span(input logic [WIDTH-1:0] g_in,
                                                 input logic [WIDTH-1:0] p_in,
                                                 input int lo, input int hi,
                                                 input logic want_p);
        logic [WIDTH-1:0] g, p, g_nx, p_nx;
        g = g_in;
        p = p_in;
        for (int k = 0; k < LVLS; k++) begin
            if (k >= lo && k < hi) begin
                g_nx = g;
                p_nx = p;
                for (int i = (1 << k); i < WIDTH; i++) begin
                    g_nx[i] = g[i] | (p[i] & g[i - (1 << k)]);
                    p_nx[i] = p[i] & p[i - (1 << k)];
                end
                g = g_nx;
                p = p_nx;
            end
        end
        return want_p ? p : g;
    endfunction

    logic stall, en;
    logic vld_p0, vld_p1, vld_p2;

    assign stall    = vld_p2 && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ---- S1: operand generate/propagate, carry-in folded into bit 0 ----
    logic [WIDTH-1:0] g_s1, p_s1;
    logic             cin_s1;
    logic [WIDTH-1:0] g_p0, p_p0;
    logic             cin_p0, a_msb_p0, b_msb_p0;

    always_comb begin
        cin_s1  = ~b_in;
        p_s1    = a ^ ~b;
        g_s1    = a & ~b;
        g_s1[0] = g_s1[0] | (p_s1[0] & cin_s1);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            g_p0     <= g_s1;
            p_p0     <= p_s1;
            cin_p0   <= cin_s1;
            a_msb_p0 <= a[WIDTH-1];
            b_msb_p0 <= b[WIDTH-1];
        end
    end

    // ---- S2: lower half of the prefix levels ----
    logic [WIDTH-1:0] gg_p1, pp_p1, psum_p1;
    logic             cin_p1, a_msb_p1, b_msb_p1;

    always_ff @(posedge clk) begin
        if (en) begin
            gg_p1    <= ks_span(g_p0, p_p0, 0, LVL_S2, 1'b0);
            pp_p1    <= ks_span(g_p0, p_p0, 0, LVL_S2, 1'b1);
            psum_p1  <= p_p0;
            cin_p1   <= cin_p0;
            a_msb_p1 <= a_msb_p0;
            b_msb_p1 <= b_msb_p0;
        end
    end

    // ---- S3: remaining prefix levels, sum and flags ----
    logic [WIDTH-1:0] gg_s3, carry_s3, diff_s3;
    logic             cout_s3, ovf_s3;

    always_comb begin
        gg_s3    = ks_span(gg_p1, pp_p1, LVL_S2, LVLS, 1'b0);
        carry_s3 = {gg_s3[WIDTH-2:0], cin_p1};
        diff_s3  = psum_p1 ^ carry_s3;
        cout_s3  = gg_s3[WIDTH-1];
        ovf_s3   = (a_msb_p1 != b_msb_p1) && (diff_s3[WIDTH-1] != a_msb_p1);
    end

    logic [WIDTH-1:0] diff_p2;
    logic             b_out_p2, ovf_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            diff_p2  <= '0;
            b_out_p2 <= 1'b0;
            ovf_p2   <= 1'b0;
        end else if (en) begin
            diff_p2  <= diff_s3;
            b_out_p2 <= ~cout_s3;
            ovf_p2   <= ovf_s3;
        end
    end

    assign out_valid = vld_p2;
    assign diff      = diff_p2;
    assign b_out     = b_out_p2;
    assign ovf       = ovf_p2;

`ifdef PSUB_FLAGS_EN
    logic zero_p2, lt_u_p2, lt_s_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_p2 <= 1'b0;
            lt_u_p2 <= 1'b0;
            lt_s_p2 <= 1'b0;
        end else if (en) begin
            zero_p2 <= ~|diff_s3;
            lt_u_p2 <= ~cout_s3;
            lt_s_p2 <= diff_s3[WIDTH-1] ^ ovf_s3;
        end
    end

    assign zero = zero_p2;
    assign lt_u = lt_u_p2;
    assign lt_s = lt_s_p2;
`endif

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Testbench for prefix_subtractor_pipe (WIDTH = 32): directed vectors, backpressure,
// reset-in-flight and randomized traffic against an arithmetic reference model.
module tb_prefix_subtractor_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        b_out;
    logic        ovf;
`ifdef PSUB_FLAGS_EN
    logic        zero, lt_u, lt_s;
`endif

    prefix_subtractor_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
`ifdef PSUB_FLAGS_EN
        ,
        .zero      (zero),
        .lt_u      (lt_u),
        .lt_s      (lt_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic        z;
        logic        lu;
        logic        ls;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    res_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    logic acc    = 1'b0;

    // Reference: plain modular difference, unsigned compare for borrow, exact signed range test for overflow.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic bi);
        res_t   r;
        longint sd;
        r.d  = x - y - 32'(bi);
        r.bo = ({1'b0, x} < ({1'b0, y} + 33'(bi)));
        sd   = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        r.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        r.z  = (r.d == 32'd0);
        r.lu = r.bo;
        r.ls = (sd < 0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called right after a negedge drive: scoreboard the upcoming edge, then advance to the next negedge.
    task automatic tick();
        #1;
        acc = 1'b0;
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: out_valid=1 diff=0x%0h with nothing outstanding", diff);
                end else begin
                    chk("sb_diff", 64'(diff), 64'(q[0].d));
                    chk("sb_b_out", 64'(b_out), 64'(q[0].bo));
                    chk("sb_ovf", 64'(ovf), 64'(q[0].ov));
`ifdef PSUB_FLAGS_EN
                    chk("sb_zero", 64'(zero), 64'(q[0].z));
                    chk("sb_lt_u", 64'(lt_u), 64'(q[0].lu));
                    chk("sb_lt_s", 64'(lt_s), 64'(q[0].ls));
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, b_in));
                acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        int   n, i, seen, base, cyc, nacc;

        vecs[0] = '{a: 32'd30,         b: 32'd20,         bin: 1'b0, d: 32'd10,         bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 32'd0,          b: 32'd1,          bin: 1'b0, d: 32'hFFFF_FFFF,  bo: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 32'h8000_0000,  b: 32'd1,          bin: 1'b0, d: 32'h7FFF_FFFF,  bo: 1'b0, ov: 1'b1};
        vecs[3] = '{a: 32'd5,          b: 32'd5,          bin: 1'b1, d: 32'hFFFF_FFFF,  bo: 1'b1, ov: 1'b0};
        vecs[4] = '{a: 32'd5,          b: 32'd5,          bin: 1'b0, d: 32'd0,          bo: 1'b0, ov: 1'b0};
        vecs[5] = '{a: 32'd100,        b: 32'd0,          bin: 1'b1, d: 32'd99,         bo: 1'b0, ov: 1'b0};
        vecs[6] = '{a: 32'h7FFF_FFFF,  b: 32'hFFFF_FFFF,  bin: 1'b0, d: 32'h8000_0000,  bo: 1'b1, ov: 1'b1};
        vecs[7] = '{a: 32'h8000_0000,  b: 32'd0,          bin: 1'b1, d: 32'h7FFF_FFFF,  bo: 1'b0, ov: 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_b_out", 64'(b_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
`ifdef PSUB_FLAGS_EN
        chk("rst_flags", 64'({zero, lt_u, lt_s}), 64'd0);
`endif
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed vectors, one at a time, with latency measured in edges including the accept edge.
        foreach (vecs[k]) begin
            a        = vecs[k].a;
            b        = vecs[k].b;
            b_in     = vecs[k].bin;
            in_valid = 1'b1;
            tick();
            chk("vec_accept", 64'(acc), 64'd1);
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            chk("vec_latency", 64'(n), 64'd3);
            chk("vec_diff", 64'(diff), 64'(vecs[k].d));
            chk("vec_b_out", 64'(b_out), 64'(vecs[k].bo));
            chk("vec_ovf", 64'(ovf), 64'(vecs[k].ov));
            tick();
        end
        chk("vec_drained", 64'(q.size()), 64'd0);

        // Streaming into a blocked consumer, then release.
        out_ready = 1'b0;
        b_in      = 1'b0;
        i         = 0;
        base      = n_out;
        for (int c = 0; c < 6; c++) begin
            a        = 32'(i);
            b        = 32'(i + 1);
            in_valid = 1'b1;
            tick();
            if (acc) i++;
        end
        chk("bp_accepted", 64'(i), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        chk("bp_held_diff", 64'(diff), 64'hFFFF_FFFF);
        out_ready = 1'b1;
        cyc = 0;
        while (i < 10 && cyc < 40) begin
            a        = 32'(i);
            b        = 32'(i + 1);
            in_valid = 1'b1;
            tick();
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_all_accepted", 64'(i), 64'd10);
        chk("bp_all_delivered", 64'(n_out - base), 64'd10);

        // Reset with three operations in flight.
        for (int c = 0; c < 3; c++) begin
            a        = $urandom;
            b        = $urandom;
            b_in     = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_diff", 64'(diff), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("mid_rst_no_stale", 64'(seen), 64'd0);
        a        = 32'd1000;
        b        = 32'd1;
        b_in     = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("post_rst_latency", 64'(n), 64'd3);
        chk("post_rst_diff", 64'(diff), 64'd998);
        tick();

        // Randomized traffic with random backpressure.
        nacc = 0;
        cyc  = 0;
        while (nacc < 10000 && cyc < 60000) begin
            a         = rnd_op();
            b         = rnd_op();
            b_in      = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) nacc++;
            cyc++;
        end
        chk("rand_accepted", 64'(nacc), 64'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("final_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
